// File: rtl/program_loader_pkg.sv
// Shared constants for the boot-time program loader.
// Loader and UART receiver state encodings plus default parameters.
package program_loader_pkg;

   localparam int DEFAULT_CLK_PER_BIT          = 868;
   localparam int DEFAULT_ROM_ADDRESS_BITWIDTH = 12;

   localparam logic [1:0] LOADER_STATE_LOAD_COUNT = 2'd0;
   localparam logic [1:0] LOADER_STATE_LOAD_WORD  = 2'd1;
   localparam logic [1:0] LOADER_STATE_DONE       = 2'd2;

   localparam logic [1:0] UART_STATE_IDLE  = 2'd0;
   localparam logic [1:0] UART_STATE_START = 2'd1;
   localparam logic [1:0] UART_STATE_DATA  = 2'd2;
   localparam logic [1:0] UART_STATE_STOP  = 2'd3;

   // Word capacity of an instruction memory with the given byte-address width.
   function automatic logic [31:0] word_capacity(input int addr_bits);
      return 32'(1) << (addr_bits - 2);
   endfunction

endpackage

// File: rtl/program_loader_uart_rx.sv
// 8N1 UART receiver with a 2-flop synchroniser and start-bit glitch rejection.
// Emits a one-cycle byte_valid or byte_error at the stop-bit sample point.
module uart_rx
   import program_loader_pkg::*;
#(
   parameter int CLK_PER_BIT = DEFAULT_CLK_PER_BIT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rxd,
   output logic       byte_valid,
   output logic [7:0] byte_data,
   output logic       byte_error
);

   localparam int CNT_W = $clog2(CLK_PER_BIT);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLK_PER_BIT - 1);

   logic             sync_1;
   logic             sync_2;
   logic             sync_prev;
   logic             falling;
   logic [1:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       shreg;

   assign falling   = sync_prev & ~sync_2;
   assign byte_data = shreg;

   // Bring the asynchronous line into the clock domain and keep one
   // extra stage so a falling edge can be detected.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_1    <= 1'b1;
         sync_2    <= 1'b1;
         sync_prev <= 1'b1;
      end else begin
         sync_1    <= rxd;
         sync_2    <= sync_1;
         sync_prev <= sync_2;
      end
   end

   // Frame sequencer: verify start bit at mid-bit, shift 8 data bits
   // LSB first, then judge the stop bit and re-arm immediately.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= UART_STATE_IDLE;
         cnt        <= '0;
         bit_idx    <= '0;
         shreg      <= '0;
         byte_valid <= 1'b0;
         byte_error <= 1'b0;
      end else begin
         byte_valid <= 1'b0;
         byte_error <= 1'b0;
         case (state)
            UART_STATE_IDLE: begin
               cnt <= '0;
               if (falling) begin
                  state <= UART_STATE_START;
               end
            end
            UART_STATE_START: begin
               if (cnt == HALF_LAST) begin
                  cnt     <= '0;
                  bit_idx <= '0;
                  state   <= sync_2 ? UART_STATE_IDLE : UART_STATE_DATA;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            UART_STATE_DATA: begin
               if (cnt == BIT_LAST) begin
                  cnt   <= '0;
                  shreg <= {sync_2, shreg[7:1]};
                  if (bit_idx == 3'd7) begin
                     state <= UART_STATE_STOP;
                  end
                  bit_idx <= bit_idx + 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               if (cnt == BIT_LAST) begin
                  cnt        <= '0;
                  byte_valid <= sync_2;
                  byte_error <= ~sync_2;
                  state      <= UART_STATE_IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: rtl/program_loader.sv
// Boot loader: streams a word count and program words from UART into
// instruction memory, holding the CPU in reset until the load completes.
module program_loader
   import program_loader_pkg::*;
#(
   parameter int CLK_PER_BIT          = DEFAULT_CLK_PER_BIT,
   parameter int ROM_ADDRESS_BITWIDTH = DEFAULT_ROM_ADDRESS_BITWIDTH
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            uart_rxd,
   output logic                            imem_wren,
   output logic [ROM_ADDRESS_BITWIDTH-1:0] imem_address,
   output logic [31:0]                     imem_write_data,
   output logic                            cpu_reset_n,
   output logic                            loading,
   output logic                            framing_error,
   output logic                            overflow
);

   localparam logic [31:0] CAPACITY = word_capacity(ROM_ADDRESS_BITWIDTH);

   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        byte_error;
   logic [1:0]  state;
   logic [1:0]  byte_idx;
   logic [23:0] partial;
   logic [31:0] word;
   logic [31:0] word_count;
   logic [31:0] word_idx;
   logic        accepting;
   logic        word_done;

   uart_rx #(
      .CLK_PER_BIT(CLK_PER_BIT)
   ) u_rx (
      .clk       (clk),
      .reset     (reset),
      .rxd       (uart_rxd),
      .byte_valid(byte_valid),
      .byte_data (byte_data),
      .byte_error(byte_error)
   );

   assign accepting = (state != LOADER_STATE_DONE);
   assign word_done = byte_valid && accepting && (byte_idx == 2'd3);
   assign word      = {byte_data, partial};
   assign loading   = ~cpu_reset_n;

   // Little-endian byte assembly; the 4th byte completes the word
   // combinationally so it can be consumed the same cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         byte_idx <= '0;
         partial  <= '0;
      end else if (byte_valid && accepting) begin
         byte_idx <= byte_idx + 1'b1;
         case (byte_idx)
            2'd0:    partial[7:0]   <= byte_data;
            2'd1:    partial[15:8]  <= byte_data;
            2'd2:    partial[23:16] <= byte_data;
            default: partial        <= partial;
         endcase
      end
   end

   // Loader FSM: latch the count, write words at consecutive addresses
   // (suppressing writes beyond capacity), then release the CPU.
   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= LOADER_STATE_LOAD_COUNT;
         word_count      <= '0;
         word_idx        <= '0;
         imem_wren       <= 1'b0;
         imem_address    <= '0;
         imem_write_data <= '0;
         cpu_reset_n     <= 1'b0;
         framing_error   <= 1'b0;
         overflow        <= 1'b0;
      end else begin
         imem_wren <= 1'b0;
         if (byte_error && accepting) begin
            framing_error <= 1'b1;
         end
         if (word_done) begin
            case (state)
               LOADER_STATE_LOAD_COUNT: begin
                  word_count <= word;
                  word_idx   <= '0;
                  if (word > CAPACITY) begin
                     overflow <= 1'b1;
                  end
                  if (word == 32'd0) begin
                     state       <= LOADER_STATE_DONE;
                     cpu_reset_n <= 1'b1;
                  end else begin
                     state <= LOADER_STATE_LOAD_WORD;
                  end
               end
               LOADER_STATE_LOAD_WORD: begin
                  if (word_idx < CAPACITY) begin
                     imem_wren       <= 1'b1;
                     imem_address    <= {word_idx[ROM_ADDRESS_BITWIDTH-3:0], 2'b00};
                     imem_write_data <= word;
                  end
                  word_idx <= word_idx + 32'd1;
                  if (word_idx + 32'd1 == word_count) begin
                     state       <= LOADER_STATE_DONE;
                     cpu_reset_n <= 1'b1;
                  end
               end
               default: begin
                  state <= state;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader with CLK_PER_BIT=16 and a 4-word ROM.
// Expected writes are queued by the stimulus and checked by a monitor.
module tb_program_loader;

   localparam int CPB = 16;
   localparam int AW  = 4;

   typedef struct {
      logic [AW-1:0] addr;
      logic [31:0]   data;
      logic          last;
   } wr_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          uart_rxd;
   logic          imem_wren;
   logic [AW-1:0] imem_address;
   logic [31:0]   imem_write_data;
   logic          cpu_reset_n;
   logic          loading;
   logic          framing_error;
   logic          overflow;

   wr_t exp_q[$];
   wr_t cur;
   int  checks = 0;
   int  errors = 0;

   program_loader #(
      .CLK_PER_BIT         (CPB),
      .ROM_ADDRESS_BITWIDTH(AW)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .uart_rxd       (uart_rxd),
      .imem_wren      (imem_wren),
      .imem_address   (imem_address),
      .imem_write_data(imem_write_data),
      .cpu_reset_n    (cpu_reset_n),
      .loading        (loading),
      .framing_error  (framing_error),
      .overflow       (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h, required %08h", name, act, exp);
      end
   endtask

   // Monitor: every write strobe must match the head of the queue.
   always @(negedge clk) begin
      if (!reset && imem_wren) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got addr=%0h data=%08h, required no write",
                     imem_address, imem_write_data);
         end else begin
            cur = exp_q.pop_front();
            chk("wr_addr", 32'(imem_address), 32'(cur.addr));
            chk("wr_data", imem_write_data, cur.data);
            chk("wr_cpu_reset_n", 32'(cpu_reset_n), 32'(cur.last));
         end
      end
   end

   task automatic push(input logic [AW-1:0] a, input logic [31:0] d,
                       input logic l);
      wr_t e;
      e.addr = a;
      e.data = d;
      e.last = l;
      exp_q.push_back(e);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      @(negedge clk);
      uart_rxd = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         uart_rxd = b[i];
         repeat (CPB) @(negedge clk);
      end
      uart_rxd = stop;
      repeat (CPB) @(negedge clk);
      uart_rxd = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) begin
         send_byte(w[8*i +: 8], 1'b1);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic release_reset();
      reset = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_wren"}, 32'(imem_wren), 32'd0);
      chk({tag, "_addr"}, 32'(imem_address), 32'd0);
      chk({tag, "_data"}, imem_write_data, 32'd0);
      chk({tag, "_cpu_reset_n"}, 32'(cpu_reset_n), 32'd0);
      chk({tag, "_loading"}, 32'(loading), 32'd1);
      chk({tag, "_framing"}, 32'(framing_error), 32'd0);
      chk({tag, "_overflow"}, 32'(overflow), 32'd0);
   endtask

   initial begin
      reset    = 1'b1;
      uart_rxd = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_vals("rst");
      release_reset();

      // Normal load
      push(4'h0, 32'h0000_0013, 1'b0);
      push(4'h4, 32'hDEAD_BEEF, 1'b1);
      send_word(32'd2);
      send_word(32'h0000_0013);
      chk("norm_loading_mid", 32'(loading), 32'd1);
      send_word(32'hDEAD_BEEF);
      chk("norm_cpu_reset_n", 32'(cpu_reset_n), 32'd1);
      chk("norm_loading", 32'(loading), 32'd0);
      chk("norm_drained", 32'(exp_q.size()), 32'd0);

      // Post-done immunity
      send_word(32'h1234_5678);
      send_word(32'h0000_0001);
      chk("done_cpu_reset_n", 32'(cpu_reset_n), 32'd1);
      chk("done_loading", 32'(loading), 32'd0);

      // Empty program
      do_reset();
      release_reset();
      for (int i = 0; i < 3; i++) send_byte(8'h00, 1'b1);
      chk("empty_before", 32'(cpu_reset_n), 32'd0);
      send_byte(8'h00, 1'b1);
      chk("empty_after", 32'(cpu_reset_n), 32'd1);
      chk("empty_overflow", 32'(overflow), 32'd0);

      // Overflow
      do_reset();
      release_reset();
      for (int i = 0; i < 4; i++) push(AW'(4 * i), 32'(i + 1), 1'b0);
      send_word(32'd5);
      chk("ovf_flag", 32'(overflow), 32'd1);
      for (int i = 1; i <= 4; i++) send_word(32'(i));
      chk("ovf_before_last", 32'(cpu_reset_n), 32'd0);
      send_word(32'd5);
      chk("ovf_cpu_reset_n", 32'(cpu_reset_n), 32'd1);
      chk("ovf_drained", 32'(exp_q.size()), 32'd0);

      // Framing error
      do_reset();
      release_reset();
      push(4'h0, 32'h1122_3344, 1'b1);
      send_word(32'd1);
      send_byte(8'hAA, 1'b0);
      chk("frm_flag", 32'(framing_error), 32'd1);
      chk("frm_still_loading", 32'(loading), 32'd1);
      send_word(32'h1122_3344);
      chk("frm_cpu_reset_n", 32'(cpu_reset_n), 32'd1);
      chk("frm_drained", 32'(exp_q.size()), 32'd0);

      // Reset mid-load, then glitch, then a fresh stream
      do_reset();
      release_reset();
      send_word(32'd2);
      send_byte(8'h55, 1'b1);
      send_byte(8'h66, 1'b1);
      do_reset();
      check_reset_vals("midrst");
      release_reset();
      uart_rxd = 1'b0;
      repeat (3) @(negedge clk);
      uart_rxd = 1'b1;
      repeat (3 * CPB) @(negedge clk);
      push(4'h0, 32'hCAFE_F00D, 1'b1);
      send_word(32'd1);
      send_word(32'hCAFE_F00D);
      chk("fresh_cpu_reset_n", 32'(cpu_reset_n), 32'd1);
      chk("fresh_framing", 32'(framing_error), 32'd0);
      chk("fresh_drained", 32'(exp_q.size()), 32'd0);

      repeat (10) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time loader that sits directly upstream of the CPU's instruction ROM and holds the CPU in reset while a program is streamed in over UART. It receives a 32-bit word count followed by that many 32-bit instructions, writes each assembled word into instruction memory at consecutive word addresses, then releases the CPU's active-low reset. After loading it ignores the serial line until the next reset.

## Interface
Parameters:
- `CLK_PER_BIT`, default 868. Clock cycles per UART bit; 868 gives 115200 baud at 100 MHz. Legal range is 4 or more.
- `ROM_ADDRESS_BITWIDTH`, default 12. Byte-address width of the instruction memory. Must equal the CPU's `ROM_ADDRESS_BITWIDTH`.

Ports:
- `clk`, input, 1 bit. The single clock.
- `reset`, input, 1 bit. Synchronous, active-high.
- `uart_rxd`, input, 1 bit. Asynchronous serial line; idles high; 8N1 framing, LSB first.
- `imem_wren`, output, 1 bit. One-cycle instruction-memory write strobe.
- `imem_address`, output, `ROM_ADDRESS_BITWIDTH` bits. Byte address of the write; always a multiple of 4.
- `imem_write_data`, output, 32 bits. Assembled instruction word.
- `cpu_reset_n`, output, 1 bit. Drives the CPU `reset_n`. Held low while loading; goes high when loading is done.
- `loading`, output, 1 bit. High from reset release until loading is done.
- `framing_error`, output, 1 bit. Sticky flag: a stop bit was sampled low.
- `overflow`, output, 1 bit. Sticky flag: the word count exceeded memory capacity.

## Operation
- Byte stream: 4 count bytes (little-endian, giving N), then 4·N instruction bytes, each word little-endian.
- The FSM has three states: `LOAD_COUNT`, `LOAD_WORD` and `DONE`.
- **Byte assembly.** A 2-bit byte counter places each received byte at `word[8*k+7 : 8*k]`, where k is the counter value. When the 4th byte arrives (k = 3), the word is complete.
- **LOAD_COUNT.**
  - On a complete word: latch N and clear the word index.
  - If N = 0, go to `DONE`; otherwise go to `LOAD_WORD`.
- **LOAD_WORD.** On each complete word:
  - Pulse `imem_wren`, with `imem_address` = index·4 and `imem_write_data` = the word.
  - Increment the index.
  - When index + 1 = N, go to `DONE`.
- **Capacity.** Capacity is C = 2^(`ROM_ADDRESS_BITWIDTH` − 2) words.
  - If N > C, set `overflow` when N is latched.
  - Words with index ≥ C are still received and counted but are not written (`imem_wren` stays low). This prevents address wrap-around.
- **DONE.**
  - `cpu_reset_n` = 1 and `loading` = 0.
  - Received bytes are ignored.
  - The state is held until `reset`.
- **Framing errors.** A byte with a bad stop bit is discarded: it neither advances the byte counter nor changes the FSM state. `framing_error` is set.
- **Reset mid-load.** Returns to `LOAD_COUNT` and clears all counters, N and flags, with `cpu_reset_n` = 0. Any partial word is lost; the host must restart the stream.

## Timing
- **Reset values:**
  - `imem_wren` = 0, `imem_address` = 0, `imem_write_data` = 0.
  - `cpu_reset_n` = 0, `loading` = 1.
  - `framing_error` = 0, `overflow` = 0.
- **uart_rx, synchronisation and start bit.**
  - `uart_rxd` passes through a 2-flop synchroniser, adding 2 cycles of latency.
  - A falling edge on the synchronised line starts a frame.
  - At `CLK_PER_BIT/2` cycles the start bit is re-checked; if the line is high, the frame is a glitch and is dropped.
- **uart_rx, data and stop bits.** Data bits are then sampled every `CLK_PER_BIT` cycles. At the stop-bit sample point:
  - if the stop bit is high, `byte_valid` pulses for 1 cycle with `byte_data`;
  - if it is low, `byte_error` pulses for 1 cycle instead.
- **uart_rx, re-arm.** The receiver re-arms the cycle after the stop-bit sample, so back-to-back frames are accepted.
- **Write latency.** `imem_wren` rises 1 cycle after the `byte_valid` of the 4th byte and is high for exactly 1 cycle. Address and data are registered together with it and hold their values until the next write.
- **Reset release.** `cpu_reset_n` rises in the same cycle as the final `imem_wren` pulse. The write therefore commits on the same edge at which the CPU first leaves reset; the CPU's first fetch happens at least one cycle later.
- **Reset priority.** `reset` wins over a simultaneous `byte_valid`.

## Structure
- Shared package or include (alongside `define.v`):
  - state encodings `LOADER_STATE_LOAD_COUNT`, `LOADER_STATE_LOAD_WORD`, `LOADER_STATE_DONE`;
  - default `CLK_PER_BIT`.
  - `ROM_ADDRESS_BITWIDTH` reuses the existing define.
- One sub-module, `uart_rx`, with ports `clk`, `reset`, `rxd`, `byte_valid`, `byte_data[7:0]`, `byte_error`, parameterised by `CLK_PER_BIT`.
- Top level: `program_loader` holds the byte assembler, FSM, counters and flags.

## Test plan
All scenarios use `CLK_PER_BIT` = 16 and `ROM_ADDRESS_BITWIDTH` = 4 (C = 4).
- **Normal load.** Send N = 2, then 0x00000013 and 0xDEADBEEF. Expect:
  - writes (addr 0, 0x00000013) and (addr 4, 0xDEADBEEF);
  - `cpu_reset_n` rises with the second strobe;
  - `loading` = 0.
- **Empty program.** Send N = 0. Expect `cpu_reset_n` high 1 cycle after the 4th count byte and no `imem_wren`.
- **Overflow.** Send N = 5, then words 1 through 5. Expect:
  - writes at addresses 0, 4, 8, 12 only;
  - `overflow` = 1;
  - `cpu_reset_n` rises after word 5.
- **Framing error.** Send N = 1, then byte 0xAA with its stop bit low, then bytes 0x44 0x33 0x22 0x11. Expect:
  - `framing_error` = 1;
  - a single write of 0x11223344 at address 0.
- **Glitch and reset mid-load.**
  - A 3-cycle low pulse on `uart_rxd` must produce no byte.
  - Assert `reset` after 2 bytes of a word: expect all outputs at their reset values. A fresh N = 1 stream then loads correctly.
- **Post-done immunity.** After DONE, send 8 more bytes. Expect no `imem_wren` and `cpu_reset_n` held at 1.
